qpsk_symbol_sched: RTL and testbench

QPSK_SYMBOL_SCHED -- requirements
Module: qpsk_symbol_sched

---
 rtl/qpsk_pkg.sv | 20 ++
 rtl/qpsk_bit_pair.sv | 47 ++++
 rtl/qpsk_symbol_sched.sv | 116 +++++++++++
 tb/tb_qpsk_symbol_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// rtl/qpsk_pkg.sv - shared types, constants and Gray index helpers for the QPSK symbol scheduler
package qpsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SPS_DEFAULT = 8;

  // Gray index: 00->0, 01->1, 11->2, 10->3
  function automatic logic [1:0] gray_idx(input logic [1:0] dibit);
    return {dibit[1], dibit[1] ^ dibit[0]};
  endfunction

  function automatic logic [1:0] gray_bits(input logic [1:0] idx);
    return {idx[1], idx[1] ^ idx[0]};
  endfunction

endpackage

// File: rtl/qpsk_bit_pair.sv
// rtl/qpsk_bit_pair.sv - serial bit intake pairing bits into a one-entry pending dibit register
module qpsk_bit_pair
  import qpsk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic       take,
  output logic       pend_valid,
  output logic [1:0] pend_dibit
);

  logic half;
  logic i_half;
  logic accept;

  // Intake stalls entirely while a completed pair waits, so a load and a
  // pair completion can never coincide.
  assign bit_ready = ~pend_valid;
  assign accept    = bit_valid & bit_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      half       <= 1'b0;
      i_half     <= 1'b0;
      pend_valid <= 1'b0;
      pend_dibit <= 2'b00;
    end else begin
      if (take) begin
        pend_valid <= 1'b0;
      end
      if (accept) begin
        if (!half) begin
          i_half <= bit_in;
          half   <= 1'b1;
        end else begin
          pend_dibit <= {i_half, bit_in};
          pend_valid <= 1'b1;
          half       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/qpsk_symbol_sched.sv
// rtl/qpsk_symbol_sched.sv - QPSK symbol scheduler; QPSK_DIFF_EN selects differential Gray encoding
module qpsk_symbol_sched
  import qpsk_pkg::*;
#(
  parameter int SPS  = SPS_DEFAULT,
  parameter int PH_W = $clog2(SPS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            bit_in,
  input  logic            bit_valid,
  output logic            bit_ready,
  output logic            Ichannel,
  output logic            Qchannel,
  output logic [PH_W-1:0] phase,
  output logic            sym_valid,
  output logic            sym_strobe,
  output logic            underrun,
  output logic [15:0]     sym_count
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPS - 1);

  state_t     state, state_n;
  logic       load;
  logic       underrun_n;
  logic       pend_valid;
  logic [1:0] pend_dibit;
  logic [1:0] sym_bits;

  qpsk_bit_pair u_pair (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .take       (load),
    .pend_valid (pend_valid),
    .pend_dibit (pend_dibit)
  );

`ifdef QPSK_DIFF_EN
  logic [1:0] prev_idx;
  logic [1:0] next_idx;

  // Reference index survives IDLE gaps; only reset returns it to 0.
  assign next_idx = prev_idx + gray_idx(pend_dibit);
  assign sym_bits = gray_bits(next_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_idx <= 2'b00;
    end else if (load) begin
      prev_idx <= next_idx;
    end
  end
`else
  assign sym_bits = pend_dibit;
`endif

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    underrun_n = 1'b0;
    case (state)
      IDLE: begin
        if (en && pend_valid) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        // en only matters at the symbol boundary; a started symbol always completes.
        if (phase == PH_LAST) begin
          if (en && pend_valid) begin
            load = 1'b1;
          end else begin
            state_n    = IDLE;
            underrun_n = en;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign sym_valid = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      Ichannel   <= 1'b0;
      Qchannel   <= 1'b0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
      sym_count  <= 16'd0;
    end else begin
      state      <= state_n;
      sym_strobe <= load;
      underrun   <= underrun_n;
      if (state == RUN && state_n == RUN && !load) begin
        phase <= phase + PH_W'(1);
      end else begin
        phase <= '0;
      end
      if (load) begin
        Ichannel  <= sym_bits[1];
        Qchannel  <= sym_bits[0];
        sym_count <= sym_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_sched.sv
// tb/tb_qpsk_symbol_sched.sv - self-checking bench for qpsk_symbol_sched (SPS=8)
module tb_qpsk_symbol_sched;

  localparam int SPS  = 8;
  localparam int PH_W = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            bit_in = 1'b0;
  logic            bit_valid = 1'b0;
  logic            bit_ready;
  logic            Ichannel;
  logic            Qchannel;
  logic [PH_W-1:0] phase;
  logic            sym_valid;
  logic            sym_strobe;
  logic            underrun;
  logic [15:0]     sym_count;

  qpsk_symbol_sched #(.SPS(SPS), .PH_W(PH_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .Ichannel   (Ichannel),
    .Qchannel   (Qchannel),
    .phase      (phase),
    .sym_valid  (sym_valid),
    .sym_strobe (sym_strobe),
    .underrun   (underrun),
    .sym_count  (sym_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, bv, b;
    logic        sv, i, q;
    logic [2:0]  ph;
    logic        st, ur, rdy;
    logic [15:0] cnt;
  } vec_t;

  vec_t       tbl[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] mprev = 2'b00;
  logic [1:0] capq[$];

  always @(negedge clk) begin
    if (!rst && sym_strobe) capq.push_back({Ichannel, Qchannel});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or event missing", name);
  endtask

  // Expected (I,Q) of the next emitted symbol for a given dibit {first, second}.
  function automatic logic [1:0] map_pair(input logic [1:0] d);
`ifdef QPSK_DIFF_EN
    logic [1:0] idx;
    case (d)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    mprev = mprev + idx;
    case (mprev)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
`else
    return d;
`endif
  endfunction

  task automatic add(input logic e, bv, b, sv, i, q, input logic [2:0] ph,
                     input logic st, ur, rdy, input logic [15:0] cnt);
    vec_t v;
    v.en = e; v.bv = bv; v.b = b; v.sv = sv; v.i = i; v.q = q;
    v.ph = ph; v.st = st; v.ur = ur; v.rdy = rdy; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mprev = 2'b00;
  endtask

  task automatic put_bit(input logic b);
    logic r;
    r = 1'b0;
    bit_valid = 1'b1;
    bit_in = b;
    for (int n = 0; n < 100; n++) begin
      r = bit_ready;
      @(posedge clk);
      #1;
      if (r) break;
    end
    if (!r) fail("put_bit");
    bit_valid = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while (int'(phase) != p && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (int'(phase) != p) fail("wait_phase");
  endtask

  logic [1:0] e1, e2, d;
  logic       r, b, half_v, half_b, exp_pend;
  logic [1:0] pq[$];
  int         nstb, last, rdy_bad, gap_bad, per_bad, n;
  logic [15:0] cnt0;

  initial begin
    // Reset: outputs clear and intake ready immediately afterwards
    do_reset();
    chk("reset_outputs", {Ichannel, Qchannel, phase, sym_valid, sym_strobe, underrun, sym_count}, 0);
    chk("reset_ready", bit_ready, 1);

    // Bits 0,0,1,1 with en=1: two symbols, then underrun
    add(1,1,0, 0,0,0,0,0,0,1,0);
    add(1,1,0, 0,0,0,0,0,0,0,0);
    add(1,1,1, 1,0,0,0,1,0,1,1);
    add(1,1,1, 1,0,0,1,0,0,1,1);
    add(1,1,1, 1,0,0,2,0,0,0,1);
    for (int k = 3; k <= 7; k++) add(1,0,0, 1,0,0,3'(k),0,0,0,1);
    add(1,0,0, 1,1,1,0,1,0,1,2);
    for (int k = 1; k <= 7; k++) add(1,0,0, 1,1,1,3'(k),0,0,1,2);
    add(1,0,0, 0,1,1,0,0,1,1,2);
    add(0,0,0, 0,1,1,0,0,0,1,2);
    foreach (tbl[i]) begin
      en = tbl[i].en; bit_valid = tbl[i].bv; bit_in = tbl[i].b;
      @(posedge clk);
      #1;
      chk($sformatf("seq_00_11[%0d]", i),
          {7'd0, sym_valid, Ichannel, Qchannel, phase, sym_strobe, underrun, bit_ready, sym_count},
          {7'd0, tbl[i].sv, tbl[i].i, tbl[i].q, tbl[i].ph, tbl[i].st, tbl[i].ur, tbl[i].rdy, tbl[i].cnt});
    end
    bit_valid = 1'b0;

    // en dropped at phase 3: symbol completes, no underrun, pending kept
    do_reset();
    en = 1'b1;
    e1 = map_pair(2'b10);
    e2 = map_pair(2'b01);
    put_bit(1); put_bit(0); put_bit(0); put_bit(1);
    wait_phase(3);
    en = 1'b0;
    for (int k = 4; k <= 7; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("endrop_phase%0d", k), {sym_valid, phase}, {1'b1, 3'(k)});
    end
    @(posedge clk);
    #1;
    chk("endrop_idle", {sym_valid, underrun, phase}, 0);
    chk("endrop_iq_hold", {Ichannel, Qchannel}, e1);
    chk("endrop_pending_kept", bit_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("endrop_stay_idle", sym_valid, 0);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("endrop_resume", {sym_valid, sym_strobe, Ichannel, Qchannel, sym_count}, {1'b1, 1'b1, e2, 16'd2});

    // Reset at phase 5 with a pending symbol
    put_bit(1); put_bit(1);
    wait_phase(5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mprev = 2'b00;
    chk("rst_mid_outputs", {Ichannel, Qchannel, phase, sym_valid, sym_strobe, underrun, sym_count}, 0);
    chk("rst_mid_ready", bit_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_pending_dropped", sym_valid, 0);

    // Reset mid-pair discards the held I half
    put_bit(0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mprev = 2'b00;
    e1 = map_pair(2'b11);
    put_bit(1); put_bit(1);
    @(posedge clk);
    #1;
    chk("rst_midpair_sym", {sym_strobe, Ichannel, Qchannel}, {1'b1, e1});

    // Dibits 01,01,10 mapping
    do_reset();
    capq.delete();
    en = 1'b1;
    put_bit(0); put_bit(1); put_bit(0); put_bit(1); put_bit(1); put_bit(0);
    n = 0;
    while (capq.size() < 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (capq.size() < 3) fail("map_wait");
    else begin
`ifdef QPSK_DIFF_EN
      chk("diff_sym0", capq[0], 2'b01);
      chk("diff_sym1", capq[1], 2'b11);
      chk("diff_sym2", capq[2], 2'b01);
`else
      chk("map_sym0", capq[0], 2'b01);
      chk("map_sym1", capq[1], 2'b01);
      chk("map_sym2", capq[2], 2'b10);
`endif
    end

    // Continuous stream over 20 symbols
    do_reset();
    en = 1'b1;
    cnt0 = sym_count;
    half_v = 1'b0; half_b = 1'b0; exp_pend = 1'b0;
    nstb = 0; last = -1; rdy_bad = 0; gap_bad = 0; per_bad = 0;
    for (int cyc = 0; cyc < 400 && nstb < 20; cyc++) begin
      r = bit_ready;
      b = 1'($urandom_range(0, 1));
      bit_valid = 1'b1;
      bit_in = b;
      @(posedge clk);
      #1;
      if (r) begin
        if (half_v) begin
          pq.push_back({half_b, b});
          exp_pend = 1'b1;
          half_v = 1'b0;
        end else begin
          half_b = b;
          half_v = 1'b1;
        end
      end
      if (sym_strobe) begin
        if (pq.size() == 0) fail("stream_pop");
        else begin
          d = pq.pop_front();
          chk($sformatf("stream_sym%0d", nstb), {Ichannel, Qchannel}, map_pair(d));
        end
        exp_pend = 1'b0;
        if (last >= 0 && cyc - last != SPS) per_bad++;
        last = cyc;
        nstb++;
      end
      if (bit_ready !== ~exp_pend) rdy_bad++;
      if (nstb > 0 && sym_valid !== 1'b1) gap_bad++;
    end
    bit_valid = 1'b0;
    chk("stream_symbols", nstb, 20);
    chk("stream_ready_cycles_bad", rdy_bad, 0);
    chk("stream_gap_cycles", gap_bad, 0);
    chk("stream_strobe_period_bad", per_bad, 0);
    chk("stream_sym_count", sym_count - cnt0, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
